regra_disparo: RTL
==================

REGRA_DISPARO -- requirements
Module: regra_disparo

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET  in  1  synchronous, active-low reset; sampled on rising CLK.
REQ-003 EN_Regras  in  1  start request; sampled only in IDLE.
REQ-004 FOU_01_UP..FOU_03_UP  in  8 each  input-1 upper memberships, MF1..MF3.
REQ-005 FOU_01_LOW..FOU_03_LOW  in  8 each  input-1 lower memberships.
REQ-006 FOU_04_UP..FOU_06_UP  in  8 each  input-2 upper memberships, MF1..MF3.
REQ-007 FOU_04_LOW..FOU_06_LOW  in  8 each  input-2 lower memberships.
REQ-008 Ativo_UP  in  6  bit n-1 set = FOU_0n upper nonzero (fuzzifier flags).
REQ-009 Regra_Idx  out  4  index of rule on current beat, 0..8.
REQ-010 Regra_UP  out  8  upper firing strength of rule Regra_Idx.
REQ-011 Regra_LOW  out  8  lower firing strength of rule Regra_Idx.
REQ-012 Regra_Valid  out  1  one-cycle beat qualifier for Regra_Idx/UP/LOW.
REQ-013 Ativo_Regras  out  9  bit k set = rule k active in last completed run.
REQ-014 N_Ativas  out  4  count of active rules in last completed run, 0..9.
REQ-015 Erro_FOU  out  1  set = some active rule in last run had Regra_LOW > Regra_UP.
REQ-016 Busy  out  1  high from LOAD through DONE inclusive.
REQ-017 Done  out  1  one-cycle pulse at run completion.

Function
REQ-018 Rule k = 3*i + j, i = input-1 MF (0..2 -> FOU_01..03), j = input-2 MF (0..2 -> FOU_04..06).
REQ-019 Rule k active iff Ativo_UP[i] and Ativo_UP[3+j] both set.
REQ-020 Active rule: Regra_UP = min(UP_i, UP_j), Regra_LOW = min(LOW_i, LOW_j), unsigned 8-bit, no widening.
REQ-021 Inactive rule: Regra_UP = Regra_LOW = 0; beat still emitted.
REQ-022 FSM states IDLE, LOAD, EVAL, DONE.
REQ-023 IDLE -> LOAD when EN_Regras = 1; else stay.
REQ-024 LOAD: snapshot all 12 FOU inputs and Ativo_UP into internal registers; clear run accumulators; -> EVAL.
REQ-025 EVAL: one rule per cycle, k = 0..8 ascending, from snapshot only; -> DONE after k = 8.
REQ-026 Outputs registered: EN_Regras sampled at edge t -> beats for k=0..8 visible in cycles t+2..t+10, Done high cycle t+11.
REQ-027 DONE: commit Ativo_Regras, N_Ativas, Erro_FOU from accumulators; Done = 1; -> IDLE.
REQ-028 Ativo_Regras/N_Ativas/Erro_FOU hold between commits; never show partial run.
REQ-029 EN_Regras ignored while Busy; no queueing; input changes after LOAD do not affect run.
REQ-030 EN_Regras held high: back-to-back runs, new LOAD the cycle after IDLE re-entry (12-cycle period).
REQ-031 Regra_Idx/UP/LOW hold last beat value when Regra_Valid = 0.
REQ-032 Erro_FOU considers active rules only.

Reset
REQ-033 RESET = 0 at edge: state IDLE, rule counter 0, all outputs 0 (Regra_Idx, Regra_UP, Regra_LOW, Regra_Valid, Ativo_Regras, N_Ativas, Erro_FOU, Busy, Done).
REQ-034 Reset mid-run aborts: no further beats, no Done, committed outputs cleared to 0.
REQ-035 RESET = 0 and EN_Regras = 1 same edge: reset wins, no run started.

Structure
REQ-036 Package fuzzy_pkg holds: membership width 8, MFs per input 3, rule count 9, rule index width 4, FSM state enum.
REQ-037 One sub-module fou_min: 8-bit unsigned two-input min, instantiated twice (upper, lower path).
REQ-038 Rule operand selection via counter-indexed mux on snapshot registers; no per-rule replicated datapath.

Verification
REQ-039 All UP=200, LOW=100, Ativo_UP=6'h3F, pulse EN_Regras -> 9 beats UP=200/LOW=100, Ativo_Regras=9'h1FF, N_Ativas=9, Erro_FOU=0, Done at t+11.
REQ-040 FOU_02_UP=180/LOW=90, FOU_05_UP=120/LOW=150, Ativo_UP=6'b010010, others 0 -> only rule 4 nonzero: UP=120, LOW=90; N_Ativas=1; Erro_FOU=0.
REQ-041 Same as 040 but FOU_02_LOW=200, FOU_05_LOW=160 -> rule 4 LOW=160>UP=120, Erro_FOU=1.
REQ-042 Start run, change all inputs to 255 at t+4, pulse EN_Regras at t+5 -> beats from snapshot, second start ignored, exactly one Done.
REQ-043 RESET=0 at t+6 mid-run -> beats stop, no Done, all outputs 0; next EN_Regras runs normally.
REQ-044 EN_Regras held high 30 cycles, Ativo_UP=0 -> Done every 12 cycles, all beats 0, N_Ativas=0.

Source files
------------

// File: rtl/regra_disparo_pkg.sv
// Shared constants, FSM state type and rule-index decode helpers for the
// interval type-2 rule firing block.
package fuzzy_pkg;

    localparam int MF_W       = 8;         // membership grade width
    localparam int MF_N       = 3;         // membership functions per input
    localparam int RULE_N     = 9;         // MF_N * MF_N rules
    localparam int RULE_IDX_W = 4;         // wide enough for 0..RULE_N-1
    localparam int FOU_N      = 2 * MF_N;  // FOU operands across both inputs

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Input-1 MF index of rule k (k = 3*i + j -> i)
    function automatic logic [1:0] mf_in1(input logic [RULE_IDX_W-1:0] k);
        logic [1:0] r;
        case (k)
            4'd0, 4'd1, 4'd2: r = 2'd0;
            4'd3, 4'd4, 4'd5: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

    // Input-2 MF index of rule k (k = 3*i + j -> j)
    function automatic logic [1:0] mf_in2(input logic [RULE_IDX_W-1:0] k);
        logic [1:0] r;
        case (k)
            4'd0, 4'd3, 4'd6: r = 2'd0;
            4'd1, 4'd4, 4'd7: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/regra_disparo_if.sv
// Start request, FOU memberships, per-rule beat stream and run summary.
interface regra_disparo_if;
    import fuzzy_pkg::*;

    logic                  EN_Regras;
    logic [MF_W-1:0]       FOU_01_UP, FOU_02_UP, FOU_03_UP;
    logic [MF_W-1:0]       FOU_01_LOW, FOU_02_LOW, FOU_03_LOW;
    logic [MF_W-1:0]       FOU_04_UP, FOU_05_UP, FOU_06_UP;
    logic [MF_W-1:0]       FOU_04_LOW, FOU_05_LOW, FOU_06_LOW;
    logic [FOU_N-1:0]      Ativo_UP;

    logic [RULE_IDX_W-1:0] Regra_Idx;
    logic [MF_W-1:0]       Regra_UP;
    logic [MF_W-1:0]       Regra_LOW;
    logic                  Regra_Valid;
    logic [RULE_N-1:0]     Ativo_Regras;
    logic [RULE_IDX_W-1:0] N_Ativas;
    logic                  Erro_FOU;
    logic                  Busy;
    logic                  Done;

    modport master (
        output EN_Regras,
        output FOU_01_UP, FOU_02_UP, FOU_03_UP, FOU_01_LOW, FOU_02_LOW, FOU_03_LOW,
        output FOU_04_UP, FOU_05_UP, FOU_06_UP, FOU_04_LOW, FOU_05_LOW, FOU_06_LOW,
        output Ativo_UP,
        input  Regra_Idx, Regra_UP, Regra_LOW, Regra_Valid,
        input  Ativo_Regras, N_Ativas, Erro_FOU, Busy, Done
    );

    modport slave (
        input  EN_Regras,
        input  FOU_01_UP, FOU_02_UP, FOU_03_UP, FOU_01_LOW, FOU_02_LOW, FOU_03_LOW,
        input  FOU_04_UP, FOU_05_UP, FOU_06_UP, FOU_04_LOW, FOU_05_LOW, FOU_06_LOW,
        input  Ativo_UP,
        output Regra_Idx, Regra_UP, Regra_LOW, Regra_Valid,
        output Ativo_Regras, N_Ativas, Erro_FOU, Busy, Done
    );

endinterface

// File: rtl/regra_disparo_fou_min.sv
// Unsigned two-input minimum (t-norm) on membership grades.
module fou_min
    import fuzzy_pkg::*;
(
    input  logic [MF_W-1:0] a,
    input  logic [MF_W-1:0] b,
    output logic [MF_W-1:0] y
);

    assign y = (a < b) ? a : b;

endmodule

// File: rtl/regra_disparo.sv
// Rule firing sequencer: snapshots both inputs' FOU memberships, then walks
// the 9 rules one per cycle through a single shared min datapath, streaming
// per-rule strengths and committing a run summary at the end.
module regra_disparo
    import fuzzy_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    regra_disparo_if.slave bus
);

    state_t                state, state_nxt;
    logic [RULE_IDX_W-1:0] rule_cnt;
    logic                  last_rule;

    logic [MF_W-1:0]       up_snap  [FOU_N];
    logic [MF_W-1:0]       low_snap [FOU_N];
    logic [FOU_N-1:0]      act_snap;

    logic [2:0]            idx_a, idx_b;
    logic [MF_W-1:0]       op_up_a, op_up_b, op_low_a, op_low_b;
    logic [MF_W-1:0]       min_up, min_low;
    logic                  rule_act;

    logic [RULE_N-1:0]     acc_act;
    logic [RULE_IDX_W-1:0] acc_n;
    logic                  acc_err;

    logic [RULE_IDX_W-1:0] beat_idx_p1;
    logic [MF_W-1:0]       beat_up_p1, beat_low_p1;
    logic                  vld_p1;
    logic [RULE_N-1:0]     ativo_regras_q;
    logic [RULE_IDX_W-1:0] n_ativas_q;
    logic                  erro_fou_q;
    logic                  done_q;

    assign last_rule = (rule_cnt == RULE_IDX_W'(RULE_N - 1));

    // State register; reset forces IDLE even if a start is requested
    always_ff @(posedge CLK) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start only from IDLE, nine EVAL beats, one DONE beat
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.EN_Regras) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_EVAL;
            ST_EVAL: if (last_rule) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot of the operands; the run never looks at live inputs again
    always_ff @(posedge CLK) begin
        if (state == ST_LOAD) begin
            up_snap[0]  <= bus.FOU_01_UP;   low_snap[0] <= bus.FOU_01_LOW;
            up_snap[1]  <= bus.FOU_02_UP;   low_snap[1] <= bus.FOU_02_LOW;
            up_snap[2]  <= bus.FOU_03_UP;   low_snap[2] <= bus.FOU_03_LOW;
            up_snap[3]  <= bus.FOU_04_UP;   low_snap[3] <= bus.FOU_04_LOW;
            up_snap[4]  <= bus.FOU_05_UP;   low_snap[4] <= bus.FOU_05_LOW;
            up_snap[5]  <= bus.FOU_06_UP;   low_snap[5] <= bus.FOU_06_LOW;
            act_snap    <= bus.Ativo_UP;
        end
    end

    // Counter-indexed operand mux: input-1 MF in slots 0..2, input-2 in 3..5
    always_comb begin
        idx_a    = {1'b0, mf_in1(rule_cnt)};
        idx_b    = 3'd3 + {1'b0, mf_in2(rule_cnt)};
        op_up_a  = up_snap[idx_a];
        op_up_b  = up_snap[idx_b];
        op_low_a = low_snap[idx_a];
        op_low_b = low_snap[idx_b];
        rule_act = act_snap[idx_a] & act_snap[idx_b];
    end

    fou_min u_min_up  (.a(op_up_a),  .b(op_up_b),  .y(min_up));
    fou_min u_min_low (.a(op_low_a), .b(op_low_b), .y(min_low));

    // p0 -> p1: register the beat, accumulate the run, commit on DONE
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rule_cnt       <= '0;
            acc_act        <= '0;
            acc_n          <= '0;
            acc_err        <= 1'b0;
            beat_idx_p1    <= '0;
            beat_up_p1     <= '0;
            beat_low_p1    <= '0;
            vld_p1         <= 1'b0;
            ativo_regras_q <= '0;
            n_ativas_q     <= '0;
            erro_fou_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    rule_cnt <= '0;
                    acc_act  <= '0;
                    acc_n    <= '0;
                    acc_err  <= 1'b0;
                end
                ST_EVAL: begin
                    beat_idx_p1 <= rule_cnt;
                    beat_up_p1  <= rule_act ? min_up  : '0;
                    beat_low_p1 <= rule_act ? min_low : '0;
                    vld_p1      <= 1'b1;
                    acc_act     <= acc_act | ({{(RULE_N-1){1'b0}}, rule_act} << rule_cnt);
                    acc_n       <= acc_n + {{(RULE_IDX_W-1){1'b0}}, rule_act};
                    acc_err     <= acc_err | (rule_act & (min_low > min_up));
                    rule_cnt    <= rule_cnt + 1'b1;
                end
                ST_DONE: begin
                    ativo_regras_q <= acc_act;
                    n_ativas_q     <= acc_n;
                    erro_fou_q     <= acc_err;
                    done_q         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Regra_Idx    = beat_idx_p1;
    assign bus.Regra_UP     = beat_up_p1;
    assign bus.Regra_LOW    = beat_low_p1;
    assign bus.Regra_Valid  = vld_p1;
    assign bus.Ativo_Regras = ativo_regras_q;
    assign bus.N_Ativas     = n_ativas_q;
    assign bus.Erro_FOU     = erro_fou_q;
    assign bus.Done         = done_q;
    assign bus.Busy         = (state != ST_IDLE);

endmodule
